// File: rtl/program_loader.sv
// Boot loader: parses a length/payload/checksum byte stream and writes the payload into RAM from BASE_ADDR.
// Latency: one cycle from each payload byte transfer to its RAM write strobe.
// Backpressure: in_ready is high only while loading; the stream stalls freely via in_valid.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] idx;
    logic [7:0]  sum;

    logic        xfer;
    logic [15:0] hdr_len;
    logic [16:0] end_addr;
    logic        overflow;

    assign in_ready = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == DATA)   || (state == CSUM);
    assign xfer     = in_valid && in_ready;

    // Full length as it will be once the high byte lands; 17 bits so a wrapping image is caught.
    assign hdr_len  = {in_data, len[7:0]};
    assign end_addr = {1'b0, BASE_ADDR} + {1'b0, hdr_len};
    assign overflow = end_addr > 17'h10000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= 16'h0000;
            idx      <= 16'h0000;
            sum      <= 8'h00;
            mem_we   <= 1'b0;
            mem_addr <= 16'h0000;
            mem_din  <= 8'h00;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= HDR_LO;
                        idx      <= 16'h0000;
                        sum      <= 8'h00;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        if (overflow) begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (hdr_len == 16'h0000) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE_ADDR + idx;
                        mem_din  <= in_data;
                        sum      <= sum + in_data;
                        idx      <= idx + 16'd1;
                        if (idx == len - 16'd1) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == sum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001: Parameter BASE_ADDR, default 16'h0000, is the RAM address of the first loaded byte.
REQ-002: clk  input  1  system clock; all state changes on the rising edge.
REQ-003: reset  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004: start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-005: in_valid  input  1  the source has a byte on in_data.
REQ-006: in_data  input  8  stream byte (header, payload or checksum).
REQ-007: in_ready  output  1  the loader accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008: mem_we  output  1  RAM write strobe, one cycle per payload byte.
REQ-009: mem_addr  output  16  RAM write address.
REQ-010: mem_din  output  8  RAM write data.
REQ-011: cpu_hold  output  1  holds the CPU in reset until a load completes successfully.
REQ-012: busy  output  1  the state is HDR_LO, HDR_HI, DATA or CSUM.
REQ-013: done  output  1  sticky success flag.
REQ-014: error  output  1  sticky failure flag.

Function
REQ-015: The state machine SHALL have the states IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE and ERROR.
REQ-016: The stream format SHALL be:
- length low byte;
- length high byte;
- LEN payload bytes;
- one checksum byte, equal to the 8-bit modulo-256 sum of the payload.
REQ-017: start in IDLE, DONE or ERROR SHALL:
- move to HDR_LO the next cycle;
- clear done, error, the byte index and the running sum.
REQ-018: start while busy SHALL be ignored.
REQ-019: in_ready SHALL be 1 exactly in HDR_LO, HDR_HI, DATA and CSUM; a state advances only on a transfer.
REQ-020: HDR_LO transfer SHALL latch LEN[7:0] and go to HDR_HI.
REQ-021: HDR_HI transfer SHALL latch LEN[15:8], then:
- if BASE_ADDR + LEN > 17'h10000 (computed 17 bits wide): go to ERROR (no address wrap-around permitted);
- else if LEN == 0: go to CSUM;
- else: go to DATA.
REQ-022: For the payload byte at index i (0-based), the loader SHALL assert mem_we=1, mem_addr=BASE_ADDR+i and mem_din=byte in the cycle after that byte's transfer (one-cycle registered latency), for exactly one cycle.
REQ-023: Each DATA transfer SHALL add the byte to the running sum modulo 256 and increment the index.
REQ-024: The transfer of byte LEN-1 SHALL move the state to CSUM.
REQ-025: Back-to-back DATA transfers SHALL produce mem_we on consecutive cycles with no stall (in_ready stays 1).
REQ-026: CSUM transfer SHALL go to DONE if the byte equals the running sum, else to ERROR.
REQ-027: In DONE, done=1 and cpu_hold=0.
REQ-028: In ERROR, error=1 and cpu_hold=1.
REQ-029: cpu_hold SHALL be 1 in every state except DONE.
REQ-030: mem_we SHALL be 0 in every cycle not specified by REQ-022; in particular, header and checksum bytes are never written.
REQ-031: While in_valid=0, the state, index, sum and outputs SHALL hold.
REQ-032: All outputs SHALL be registered, except in_ready, which is decoded from the state.

Reset
REQ-033: While reset=1 at a clock edge, the loader SHALL enter IDLE with:
- index=0, sum=0, LEN=0;
- mem_we=0, mem_addr=16'h0000, mem_din=8'h00;
- done=0, error=0, busy=0, cpu_hold=1, in_ready=0.
REQ-034: reset SHALL take priority over start and over any transfer in the same cycle.
REQ-035: reset mid-load SHALL abort the load; no further mem_we pulses occur, including one pending from a transfer in the reset cycle.

Verification
REQ-036: The bench SHALL cover:
- Nominal: BASE=0, start, stream 03 00 11 22 33 66 with in_valid held high -> writes 11@0000, 22@0001, 33@0002 on three consecutive cycles; done=1, cpu_hold=0, error=0.
- Bad checksum: stream 02 00 01 02 04 -> writes 01@0000 and 02@0001; then error=1, cpu_hold=1, done=0.
- Overflow: BASE=16'hFFFE, stream 03 00 -> ERROR immediately after the header; no mem_we pulse; a length of 02 00 instead is accepted and writes FFFE and FFFF.
- Zero length and stalls: stream 00 00 00 -> done=1 with no writes; random in_valid gaps in the nominal case -> identical write sequence, one write per transfer.
- Reset and start edge cases: reset asserted after 2 of 3 payload bytes -> IDLE, no further writes, all flags 0, cpu_hold=1; start pulsed during DATA -> ignored, index unchanged.
